// File: rtl/vit_dbg_pkg.sv
// Shared types and default sizing for the Viterbi debug bridge.
// Pulled in by the bridge, its interface and the soft-symbol FIFO.
package vit_dbg_pkg;

   localparam int DEF_SOFT_W     = 8;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_STATE_W    = 6;
   localparam int DEF_CAP_DEPTH  = 32;
   localparam int DEF_DRAIN_TO   = 256;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } vit_state_e;

endpackage

// File: rtl/vit_debug_bridge_if.sv
// Soft-symbol stream toward the decoder plus the decoder's bit output.
// The bridge takes the master side; the decoder (or a bench) takes the slave side.
interface vit_debug_bridge_if
   import vit_dbg_pkg::*;
#(
   parameter int SOFT_W  = DEF_SOFT_W,
   parameter int STATE_W = DEF_STATE_W
) ();

   logic signed [SOFT_W-1:0]  soft_out;
   logic                      soft_valid;
   logic                      soft_ready;
   logic                      dec_valid;
   logic                      dec_bit;
   logic        [STATE_W-1:0] dec_last_state;

   modport master (
      output soft_out, soft_valid,
      input  soft_ready, dec_valid, dec_bit, dec_last_state
   );

   modport slave (
      input  soft_out, soft_valid,
      output soft_ready, dec_valid, dec_bit, dec_last_state
   );

endinterface

// File: rtl/vit_soft_fifo.sv
// First-word-fall-through soft-symbol FIFO; head is valid whenever count is non-zero.
// A push on full is taken only when a pop frees a slot on the same edge.
module vit_soft_fifo
   import vit_dbg_pkg::*;
#(
   parameter int W     = DEF_SOFT_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic signed [W-1:0]        push_data,
   input  logic                       pop,
   output logic signed [W-1:0]        head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic signed [W-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vit_debug_bridge.sv
// Host-driven debug bridge: queues soft symbols, streams them to a Viterbi decoder,
// captures the decoded bits and finishes once the decoder goes quiet or capture fills.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for a host_go edge; pushes still land in the FIFO
//  ST_STREAM | FIFO drives the decoder; decoded bits are captured
//  ST_DRAIN  | FIFO empty; capture continues until quiet timeout or full
//  ST_DONE   | capture frozen, done=1 until a host_ack edge
module vit_debug_bridge
   import vit_dbg_pkg::*;
#(
   parameter int SOFT_W     = DEF_SOFT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int STATE_W    = DEF_STATE_W,
   parameter int CAP_DEPTH  = DEF_CAP_DEPTH,
   parameter int DRAIN_TO   = DEF_DRAIN_TO
) (
   input  logic                          clk,
   input  logic                          sys_rst_n,
   input  logic                          clr,
   input  logic                          host_wr,
   input  logic signed [SOFT_W-1:0]      host_data,
   input  logic                          host_go,
   input  logic                          host_ack,
   vit_debug_bridge_if.master            dbg,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CAP_DEPTH-1:0]          cap_bits,
   output logic [$clog2(CAP_DEPTH):0]    cap_count,
   output logic [STATE_W-1:0]            cap_last_state,
   output logic                          busy,
   output logic                          done,
   output logic                          push_ovf,
   output logic                          cap_ovf
);

   localparam int                CIW       = $clog2(CAP_DEPTH);
   localparam int                DCW       = $clog2(DRAIN_TO + 1);
   localparam logic [CIW:0]      CAP_FULL  = (CIW+1)'(CAP_DEPTH);
   localparam logic [DCW-1:0]    DRAIN_TC  = DCW'(DRAIN_TO - 1);

   vit_state_e               state;
   logic                     wr_q, go_q, ack_q, armed;
   logic                     push_ev, go_ev, ack_ev;
   logic                     fifo_empty, fifo_full;
   logic signed [SOFT_W-1:0] fifo_head;
   logic                     soft_valid, pop;
   logic                     cap_en, cap_room;
   logic [DCW-1:0]           drain_cnt;

   // armed stays low for the first edge after reset/clr so a level already high is not seen as an edge
   assign push_ev = armed & host_wr  & ~wr_q;
   assign go_ev   = armed & host_go  & ~go_q;
   assign ack_ev  = armed & host_ack & ~ack_q;

   assign soft_valid     = (state == ST_STREAM) & ~fifo_empty;
   assign pop            = soft_valid & dbg.soft_ready;
   assign dbg.soft_valid = soft_valid;
   assign dbg.soft_out   = soft_valid ? fifo_head : '0;

   assign cap_en   = ((state == ST_STREAM) || (state == ST_DRAIN)) & dbg.dec_valid;
   assign cap_room = (cap_count != CAP_FULL);

   vit_soft_fifo #(
      .W     (SOFT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (sys_rst_n),
      .clr       (clr),
      .push      (push_ev),
      .push_data (host_data),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state          <= ST_IDLE;
         wr_q           <= 1'b0;
         go_q           <= 1'b0;
         ack_q          <= 1'b0;
         armed          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         push_ovf       <= 1'b0;
         cap_ovf        <= 1'b0;
         cap_bits       <= '0;
         cap_count      <= '0;
         cap_last_state <= '0;
         drain_cnt      <= '0;
      end else if (clr) begin
         state          <= ST_IDLE;
         wr_q           <= 1'b0;
         go_q           <= 1'b0;
         ack_q          <= 1'b0;
         armed          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         push_ovf       <= 1'b0;
         cap_ovf        <= 1'b0;
         cap_bits       <= '0;
         cap_count      <= '0;
         cap_last_state <= '0;
         drain_cnt      <= '0;
      end else begin
         wr_q  <= host_wr;
         go_q  <= host_go;
         ack_q <= host_ack;
         armed <= 1'b1;

         if (push_ev && fifo_full && !pop) push_ovf <= 1'b1;

         if (cap_en) begin
            if (cap_room) begin
               cap_bits[cap_count[CIW-1:0]] <= dbg.dec_bit;
               cap_count                    <= cap_count + (CIW+1)'(1);
               cap_last_state               <= dbg.dec_last_state;
            end else begin
               cap_ovf <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (go_ev) begin
                  state          <= ST_STREAM;
                  busy           <= 1'b1;
                  cap_bits       <= '0;
                  cap_count      <= '0;
                  cap_last_state <= '0;
                  cap_ovf        <= 1'b0;
               end
            end
            ST_STREAM: begin
               drain_cnt <= DRAIN_TC;
               if (fifo_empty) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!cap_room || (!dbg.dec_valid && drain_cnt == '0)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (dbg.dec_valid) begin
                  drain_cnt <= DRAIN_TC;
               end else begin
                  drain_cnt <= drain_cnt - DCW'(1);
               end
            end
            ST_DONE: begin
               if (ack_ev) begin
                  state <= ST_IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/vit_debug_bridge.md
VIT_DEBUG_BRIDGE -- requirements
Module: vit_debug_bridge

Interface
REQ-001 Parameter SOFT_W, default 8, signed soft-symbol width.
REQ-002 Parameter FIFO_DEPTH, default 16, soft-symbol FIFO entries; power of two, at least 2.
REQ-003 Parameter STATE_W, default 6, decoder state width.
REQ-004 Parameter CAP_DEPTH, default 32, maximum captured decoded bits.
REQ-005 Parameter DRAIN_TO, default 256, idle cycles in DRAIN before completion.
REQ-006 Port clk  in  1  single clock; all logic is in this domain.
REQ-007 Port sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-008 Port clr  in  1  synchronous clear, equivalent to reset for all state.
REQ-009 Port host_wr  in  1  host level strobe; its rising edge pushes host_data.
REQ-010 Port host_data  in  SOFT_W  signed soft symbol to push.
REQ-011 Port host_go  in  1  host level; its rising edge starts a run.
REQ-012 Port host_ack  in  1  host level; its rising edge releases DONE.
REQ-013 Port soft_out / soft_valid / soft_ready  out/out/in  SOFT_W/1/1  stream to the decoder.
REQ-014 Port dec_valid / dec_bit / dec_last_state  in  1/1/STATE_W  decoder output.
REQ-015 Port fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 Port cap_bits / cap_count  out  CAP_DEPTH / clog2(CAP_DEPTH)+1  captured bits and how many were captured.
REQ-017 Port cap_last_state  out  STATE_W  dec_last_state at the most recent captured bit.
REQ-018 Port busy / done / push_ovf / cap_ovf  out  1 each  status; the two overflow flags are sticky.

Function
REQ-019 Edge detection: host_wr, host_go and host_ack SHALL each be registered; an event is in=1 while the registered copy is 0.
- Exactly one action per rising edge.
- Each action takes effect at the same clock edge.
REQ-020 Push on a host_wr edge in any state:
- Not full: the FIFO stores host_data and fifo_count increments at that edge.
- Full: the data is dropped and push_ovf is set.
REQ-021 FSM states are IDLE, STREAM, DRAIN and DONE; busy=1 in STREAM and DRAIN only.
REQ-022 IDLE to STREAM on a host_go edge.
- Entering STREAM clears cap_bits, cap_count, cap_last_state and cap_ovf.
- host_go edges outside IDLE are ignored.
REQ-023 STREAM handshake:
- soft_valid=1 whenever the FIFO is non-empty.
- soft_out is the FIFO head.
- A pop occurs on every cycle with soft_valid and soft_ready both 1.
REQ-024 While soft_valid=1 and soft_ready=0, soft_out SHALL remain stable.
REQ-025 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
- Push on full with a simultaneous pop is accepted.
REQ-026 STREAM to DRAIN on the cycle after the FIFO becomes empty.
- soft_valid=0 in IDLE, DRAIN and DONE.
REQ-027 Capture runs in STREAM and DRAIN; each cycle with dec_valid=1:
- cap_count < CAP_DEPTH: dec_bit is written to cap_bits[cap_count], cap_count increments, cap_last_state <= dec_last_state.
- cap_count == CAP_DEPTH: the bit is discarded and cap_ovf is set.
REQ-028 DRAIN counter:
- It counts consecutive cycles with dec_valid=0 and restarts at 0 on any dec_valid.
- DRAIN to DONE when the counter reaches DRAIN_TO-1 or cap_count reaches CAP_DEPTH.
REQ-029 DONE behaviour:
- done=1; the capture outputs are held.
- A host_ack edge returns the FSM to IDLE and clears done; captures are held until the next run.
REQ-030 In IDLE and DONE, dec_valid SHALL be ignored.
REQ-031 clr mid-run SHALL force IDLE, empty the FIFO, and clear all capture and overflow state on the next edge.

Reset
REQ-032 On sys_rst_n=0 the block SHALL enter IDLE immediately, without waiting for a clock.
- Empties the FIFO and clears all edge registers.
- All outputs read 0: soft_valid, soft_out, fifo_count, cap_bits, cap_count, cap_last_state, busy, done, push_ovf, cap_ovf.
REQ-033 Reset deassertion SHALL NOT create a spurious edge event, even if host_wr, host_go or host_ack is 1.

Structure
REQ-034 Package vit_dbg_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-035 The FIFO SHALL be a sub-module, vit_soft_fifo, with first-word-fall-through, the same async active-low reset, and clr.

Verification
REQ-036 Push 0x05, 0xFB, 0x7F and hold soft_ready=1, then pulse host_go:
- soft_out is 5, -5, 127 on three consecutive cycles.
- The FSM then enters DRAIN.
REQ-037 Push 17 symbols with FIFO_DEPTH=16:
- fifo_count=16 and push_ovf=1.
- A push during the same cycle as a pop is accepted.
REQ-038 Hold soft_ready=0 for 5 cycles with the FIFO non-empty: soft_out stays constant and fifo_count is unchanged.
REQ-039 Drive dec_valid with bits 1,0,1,1 and last_state 0x2A, then leave it idle:
- cap_bits[3:0]=4'b1101, cap_count=4, cap_last_state=0x2A.
- done=1 after 256 idle cycles.
- A host_ack edge returns the FSM to IDLE.
REQ-040 Drive 40 dec_valid pulses with CAP_DEPTH=32: cap_count=32, cap_ovf=1, and done is asserted early.
REQ-041 Assert sys_rst_n=0 mid-STREAM with host_go held at 1:
- All outputs are 0 and the FSM is IDLE.
- No run starts after release until host_go toggles.
